// File: rtl/ro_ctrl_pkg.sv
// Shared definitions for the ring-oscillator measurement sequencer:
// FSM state encoding, the settle default and the SG13G2 acceptance band.
package ro_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SNAP,
    GATE,
    STOP,
    EVAL,
    DONE
  } ro_state_e;

  localparam int SETTLE_CYCLES_DEFAULT = 2;

  // Edge counts for a 1024-cycle window on a 100 MHz system clock,
  // bracketing the 50-70 MHz band expected from IHP SG13G2 silicon.
  localparam logic [31:0] SG13G2_LO_BOUND = 32'd512;
  localparam logic [31:0] SG13G2_HI_BOUND = 32'd717;

endpackage

// File: rtl/ro_window_timer.sv
// Loadable down-counter with a zero flag; times both the settle hold and
// the gate window of the measurement sequencer.
module ro_window_timer #(
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIN_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIN_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - WIN_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator measurement sequencer: gates ro_enable, snapshots ro_count
// and range-checks the delta. Define RO_AVG_EN to average 2^AVG_LOG2 windows.
module ro_measure_ctrl
  import ro_ctrl_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,  // must be >= 1
  parameter int AVG_LOG2      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_cycles,
  input  logic [CNT_W-1:0] lo_bound,
  input  logic [CNT_W-1:0] hi_bound,
  input  logic [CNT_W-1:0] ro_count,
  output logic             ro_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             pass,
  output logic             fail,
  output logic             err_cfg
);

  ro_state_e        state, state_next;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] lo_q, hi_q;
  logic [CNT_W-1:0] snap_a, snap_b, delta, meas;
  logic             snap_pending;
  logic             accept, in_window, last_win;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [WIN_W-1:0] tmr_val;

  // A start coinciding with the done pulse lands in IDLE but must be dropped.
  assign accept    = start && (state == IDLE) && !done;
  assign delta     = snap_b - snap_a;
  assign in_window = (meas >= lo_q) && (meas <= hi_q);

`ifdef RO_AVG_EN
  localparam int SUM_W   = CNT_W + AVG_LOG2;
  localparam int NUM_WIN = 1 << AVG_LOG2;

  logic [SUM_W-1:0]  sum, sum_next;
  logic [AVG_LOG2:0] win_idx;

  assign sum_next = sum + SUM_W'(delta);
  assign last_win = (win_idx == (AVG_LOG2 + 1)'(NUM_WIN - 1));
  assign meas     = CNT_W'(sum_next >> AVG_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      win_idx <= '0;
    end else if (accept) begin
      sum     <= '0;
      win_idx <= '0;
    end else if (state == EVAL) begin
      sum     <= sum_next;
      win_idx <= win_idx + 1'b1;
    end
  end
`else
  logic unused_avg;
  assign unused_avg = ^AVG_LOG2;
  assign last_win   = 1'b1;
  assign meas       = delta;
`endif

  ro_window_timer #(
    .WIN_W(WIN_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .dec     (tmr_dec),
    .zero    (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (win_cycles == '0) begin
          state_next = DONE;
        end else begin
          state_next = ARM;
          tmr_load   = 1'b1;
          tmr_val    = WIN_W'(SETTLE_CYCLES - 1);
        end
      end
      ARM: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_next = SNAP;
      end
      SNAP: begin
        state_next = GATE;
        tmr_load   = 1'b1;
        tmr_val    = win_q - WIN_W'(1);
      end
      GATE: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_next = STOP;
      end
      STOP: state_next = EVAL;
      EVAL: begin
        if (last_win) begin
          state_next = DONE;
        end else begin
          state_next = ARM;
          tmr_load   = 1'b1;
          tmr_val    = WIN_W'(SETTLE_CYCLES - 1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      snap_a       <= '0;
      snap_b       <= '0;
      snap_pending <= 1'b0;
      ro_enable    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      err_cfg      <= 1'b0;
    end else begin
      done         <= (state == DONE);
      snap_pending <= (state == SNAP);
      // Opening snapshot trails SNAP by one edge so the delta covers exactly
      // the win_cycles GATE edges, matching the closing snapshot in STOP.
      if (snap_pending)              snap_a    <= ro_count;
      if (state == STOP)             snap_b    <= ro_count;
      if (state == GATE && tmr_zero) ro_enable <= 1'b0;
      if (state == DONE)             busy      <= 1'b0;

      if (accept) begin
        win_q     <= win_cycles;
        lo_q      <= lo_bound;
        hi_q      <= hi_bound;
        busy      <= 1'b1;
        ro_enable <= (win_cycles != '0);
        result    <= '0;
        pass      <= 1'b0;
        fail      <= (win_cycles == '0);
        err_cfg   <= (win_cycles == '0);
      end

      if (state == EVAL) begin
        if (last_win) begin
          result <= meas;
          pass   <= in_window;
          fail   <= !in_window;
        end else begin
          ro_enable <= 1'b1;
        end
      end
    end
  end

endmodule
